// File: rtl/spi_flash_reader_if.sv
// rtl/spi_flash_reader_if.sv - register-port bundle between the flash reader and the SPI master core
//
// Signals:
//   spi_select   chip-select for the core's register port
//   spi_addr     register index (0 rx, 1 tx, 3 control, 5 slave-enable)
//   spi_wdata    write data
//   spi_write_n  write strobe, active low
//   spi_read_n   read strobe, active low
//   spi_rdata    registered read data from the core
//   spi_rxrdy    core has a received byte (RRDY)
//   spi_txrdy    core can accept a transmit byte (TRDY)
// Modports: master = flash reader side, slave = SPI core side.
interface spi_flash_reader_if;
    logic        spi_select;
    logic [2:0]  spi_addr;
    logic [15:0] spi_wdata;
    logic        spi_write_n;
    logic        spi_read_n;
    logic [15:0] spi_rdata;
    logic        spi_rxrdy;
    logic        spi_txrdy;

    modport master (
        output spi_select, spi_addr, spi_wdata, spi_write_n, spi_read_n,
        input  spi_rdata, spi_rxrdy, spi_txrdy
    );

    modport slave (
        input  spi_select, spi_addr, spi_wdata, spi_write_n, spi_read_n,
        output spi_rdata, spi_rxrdy, spi_txrdy
    );
endinterface

// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - streams a flash byte range through the SPI master core register port
//
// Runs the flash READ command via the SPI core's register port and returns the
// data bytes on a valid/ready byte stream.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   start, addr, len      request (sampled only while idle)
//   busy, done            transfer in progress / one-cycle completion pulse
//   out_data, out_valid,
//   out_ready             returned byte stream
//   spi                   SPI core register port (spi_flash_reader_if.master)
//
// Build option: define SPI_FLASH_FAST_READ_EN to issue FAST READ (0x0B) with one
// extra dummy byte after the address; otherwise plain READ (0x03) is used.
module spi_flash_reader (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [23:0]        addr,
    input  logic [15:0]        len,
    output logic               busy,
    output logic               done,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    spi_flash_reader_if.master spi
);

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0]  CMD_BYTE = 8'h0B;
    localparam logic [16:0] HDR      = 17'd5;
`else
    localparam logic [7:0]  CMD_BYTE = 8'h03;
    localparam logic [16:0] HDR      = 17'd4;
`endif

    localparam logic [2:0]  REG_RX   = 3'd0;
    localparam logic [2:0]  REG_TX   = 3'd1;
    localparam logic [2:0]  REG_CTL  = 3'd3;
    localparam logic [2:0]  REG_SS   = 3'd5;
    localparam logic [15:0] SS_MASK  = 16'h0001;
    localparam logic [15:0] CTL_SSO  = 16'h0400;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEL_WR,
        ST_CTL_WR,
        ST_TX_WR,
        ST_RX_WAIT,
        ST_RX_RD,
        ST_OUT,
        ST_REL_WR,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        cnt_q, cnt_d;           // 0 = first active cycle, 1 = second
    logic [16:0] idx_q, idx_d;           // bytes exchanged so far, header included
    logic [23:0] addr_q, addr_d;
    logic [15:0] len_q, len_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        spi_select_q, spi_select_d;
    logic        spi_write_n_q, spi_write_n_d;
    logic        spi_read_n_q, spi_read_n_d;
    logic [2:0]  spi_addr_q, spi_addr_d;
    logic [15:0] spi_wdata_q, spi_wdata_d;

    logic        access_last;
    logic        launch_wr, launch_rd, finish;
    logic [2:0]  acc_reg;
    logic [15:0] acc_data;
    logic [7:0]  tx_byte;
    logic [16:0] total;
    logic        unused_rdata_hi;

    assign unused_rdata_hi = ^spi.spi_rdata[15:8];

    // spi_select_q doubles as "access in progress": each access state launches
    // its access while select is low, and leaves on the second active cycle.
    assign access_last = spi_select_q & cnt_q;
    assign total       = {1'b0, len_q} + HDR;

    always_comb begin
        tx_byte = 8'h00;
        case (idx_q)
            17'd0:   tx_byte = CMD_BYTE;
            17'd1:   tx_byte = addr_q[23:16];
            17'd2:   tx_byte = addr_q[15:8];
            17'd3:   tx_byte = addr_q[7:0];
            default: tx_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        addr_d        = addr_q;
        len_d         = len_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        spi_select_d  = spi_select_q;
        spi_write_n_d = spi_write_n_q;
        spi_read_n_d  = spi_read_n_q;
        spi_addr_d    = spi_addr_q;
        spi_wdata_d   = spi_wdata_q;
        launch_wr     = 1'b0;
        launch_rd     = 1'b0;
        finish        = 1'b0;
        acc_reg       = REG_RX;
        acc_data      = 16'h0000;

        if (spi_select_q && !cnt_q) begin
            cnt_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d = addr;
                    len_d  = len;
                    idx_d  = 17'd0;
                    busy_d = 1'b1;
                    if (len == 16'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_SEL_WR;
                        launch_wr = 1'b1;
                        acc_reg   = REG_SS;
                        acc_data  = SS_MASK;
                    end
                end
            end
            ST_SEL_WR: begin
                if (access_last) begin
                    finish  = 1'b1;
                    state_d = ST_CTL_WR;
                end
            end
            ST_CTL_WR: begin
                if (!spi_select_q) begin
                    launch_wr = 1'b1;
                    acc_reg   = REG_CTL;
                    acc_data  = CTL_SSO;
                end else if (access_last) begin
                    finish  = 1'b1;
                    state_d = ST_TX_WR;
                end
            end
            ST_TX_WR: begin
                if (!spi_select_q) begin
                    if (spi.spi_txrdy) begin
                        launch_wr = 1'b1;
                        acc_reg   = REG_TX;
                        acc_data  = {8'h00, tx_byte};
                    end
                end else if (access_last) begin
                    finish  = 1'b1;
                    state_d = ST_RX_WAIT;
                end
            end
            ST_RX_WAIT: begin
                if (spi.spi_rxrdy) begin
                    launch_rd = 1'b1;
                    acc_reg   = REG_RX;
                    state_d   = ST_RX_RD;
                end
            end
            ST_RX_RD: begin
                if (access_last) begin
                    finish = 1'b1;
                    idx_d  = idx_q + 17'd1;
                    if (idx_q < HDR) begin
                        state_d = ST_TX_WR;
                    end else begin
                        out_data_d  = spi.spi_rdata[7:0];
                        out_valid_d = 1'b1;
                        state_d     = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                // No new dummy byte is issued until the consumer takes this one,
                // so SCLK stays idle under backpressure while CS is held by SSO.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = (idx_q == total) ? ST_REL_WR : ST_TX_WR;
                end
            end
            ST_REL_WR: begin
                if (!spi_select_q) begin
                    launch_wr = 1'b1;
                    acc_reg   = REG_CTL;
                    acc_data  = 16'h0000;
                end else if (access_last) begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (launch_wr || launch_rd) begin
            spi_select_d  = 1'b1;
            spi_write_n_d = ~launch_wr;
            spi_read_n_d  = ~launch_rd;
            spi_addr_d    = acc_reg;
            spi_wdata_d   = acc_data;
            cnt_d         = 1'b0;
        end
        if (finish) begin
            spi_select_d  = 1'b0;
            spi_write_n_d = 1'b1;
            spi_read_n_d  = 1'b1;
            cnt_d         = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 1'b0;
            idx_q         <= 17'd0;
            addr_q        <= 24'd0;
            len_q         <= 16'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= 8'd0;
            spi_select_q  <= 1'b0;
            spi_write_n_q <= 1'b1;
            spi_read_n_q  <= 1'b1;
            spi_addr_q    <= 3'd0;
            spi_wdata_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            spi_select_q  <= spi_select_d;
            spi_write_n_q <= spi_write_n_d;
            spi_read_n_q  <= spi_read_n_d;
            spi_addr_q    <= spi_addr_d;
            spi_wdata_q   <= spi_wdata_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign spi.spi_select  = spi_select_q;
    assign spi.spi_write_n = spi_write_n_q;
    assign spi.spi_read_n  = spi_read_n_q;
    assign spi.spi_addr    = spi_addr_q;
    assign spi.spi_wdata   = spi_wdata_q;

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

Sequencer that streams a byte range out of the serial configuration flash. It runs the flash READ command through the existing SPI master core by driving that core's 3-bit register port, and delivers the returned bytes on a valid/ready byte stream. It sits between the SPI master and a boot-loader or DMA client, and replaces CPU-driven polling of the SPI core for bulk flash reads.

## Interface
- No parameters; the slave-select mask is fixed at 16'h0001.
- clk  in  1  system clock, same clock as the SPI master core.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only while busy=0.
- addr  in  24  flash byte address; captured on an accepted start.
- len  in  16  number of data bytes to return; captured on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the transfer is complete.
- out_data  out  8  returned flash byte.
- out_valid  out  1  out_data is valid; held until out_ready.
- out_ready  in  1  consumer accepts the byte.
- spi_select  out  1  SPI core chip-select for the register port.
- spi_addr  out  3  SPI core register index (0 rx, 1 tx, 3 control, 5 slave-enable).
- spi_wdata  out  16  SPI core write data.
- spi_write_n  out  1  SPI core write strobe, active low.
- spi_read_n  out  1  SPI core read strobe, active low.
- spi_rdata  in  16  SPI core registered read data.
- spi_rxrdy  in  1  SPI core dataavailable (RRDY).
- spi_txrdy  in  1  SPI core readyfordata (TRDY).

## Operation
- Reset values:
  - busy=0, done=0, out_valid=0, out_data=0.
  - spi_select=0, spi_write_n=1, spi_read_n=1, spi_addr=0, spi_wdata=0.
  - State is IDLE.
- Bus access rule:
  - Every SPI register access holds spi_select=1 with the strobe low for exactly 2 cycles.
  - Each access is followed by at least 1 cycle with spi_select=0, spi_write_n=1, spi_read_n=1.
  - For reads, spi_rdata[7:0] is captured at the end of the 2nd active cycle.
- States:
  - IDLE: on start, latch addr and len. If len==0, go to DONE with no SPI traffic. Otherwise go to SEL_WR.
  - SEL_WR: write reg 5 = 16'h0001.
  - CTL_WR: write reg 3 = 16'h0400, which sets SSO so CS is held low across bytes.
  - TX_WR: wait for spi_txrdy=1, then write reg 1 with the next byte.
    - Byte order: command 8'h03, then addr[23:16], addr[15:8], addr[7:0], then 8'h00 dummies for the data phase.
  - RX_WAIT: wait for spi_rxrdy=1.
  - RX_RD: read reg 0; this clears RRDY in the core.
    - If the byte is a header byte (index < HDR), discard it and return to TX_WR.
    - Otherwise load out_data, set out_valid, and go to OUT.
  - OUT: hold out_valid until out_ready. On handshake, decrement the remaining count. If the count is 0, go to REL_WR; otherwise go to TX_WR.
  - REL_WR: write reg 3 = 16'h0000 to release SSO; CS rises. Go to DONE.
  - DONE: pulse done for 1 cycle, drop busy, go to IDLE.
- Only one byte is in flight at a time. The core's TOE/ROE overrun flags must never set.
- Byte index counter is 17 bits wide: it counts HDR + len bytes, and len=65535 must not overflow.
- A start pulse while busy=1 is ignored; it is neither queued nor allowed to corrupt the latched addr/len.
- Backpressure: while out_ready=0, no further dummy byte is issued. SCLK stays idle and CS stays low.
- Reset mid-transfer returns everything to reset values immediately. The SPI core shares reset_n, so CS deasserts.

## Timing
- start to first spi_select assertion: 1 cycle.
- Each register access occupies 3 cycles (2 active + 1 idle).
- The header write sequence (SEL_WR, CTL_WR) costs 6 cycles.
- Per byte: TX write (3 cycles), plus the SPI shift time (18 cycles at sys_clk/2), plus the RX read (3 cycles), plus the OUT handshake (at least 1 cycle).
- out_valid rises the cycle after the RX_RD capture cycle.
- done rises 1 cycle after the REL_WR idle cycle and lasts exactly 1 cycle.
- busy falls in the same cycle that done is high.

## Configuration
- SPI_FLASH_FAST_READ_EN:
  - Defined: the command byte is 8'h0B, and one extra 8'h00 dummy follows the address. HDR=5 received bytes are discarded.
  - Undefined: the command byte is 8'h03 and HDR=4.

## Test plan
- start, addr=24'h012345, len=3; flash model returns A0,A1,A2 -> MOSI stream 03 01 23 45 00 00 00; out bytes A0,A1,A2; then one done pulse; CS is low for the whole transfer.
- len=0 -> done 2 cycles after start; spi_select never asserted.
- len=2 with out_ready held low for 50 cycles after the first byte -> out_valid and out_data held stable; no SCLK activity until ready; second byte is correct.
- start re-pulsed mid-transfer with a different addr -> ignored; the data and byte count of the original request are unchanged.
- reset_n asserted during a data byte -> busy=0, out_valid=0, spi strobes inactive in the same cycle. A new start then completes normally.
- SPI_FLASH_FAST_READ_EN defined, addr=0, len=1 -> MOSI stream 0B 00 00 00 00 00; exactly 5 bytes discarded before the output byte.
